// File: rtl/rv32i_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data wins arbitration unless a waiting fetch has been passed over STARVE_MAX times in a row.
module rv32i_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              ifetch_req_i,
    input  logic [ADDR_W-1:0] ifetch_addr_i,
    input  logic              ifetch_flush_i,
    output logic [DATA_W-1:0] ifetch_rdata_o,
    output logic              ifetch_valid_o,
    output logic              stall_fetch_o,
    input  logic              dmem_re_i,
    input  logic              dmem_we_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              dmem_valid_o,
    output logic              stall_exec_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t            state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] ifetch_hold_q, ifetch_hold_d;
    logic [DATA_W-1:0] dmem_hold_q, dmem_hold_d;
    logic              flush_seen_q, flush_seen_d;
    logic              store_q, store_d;

    logic dreq;
    logic starve_hit;
    logic grant_d;
    logic grant_i;
    logic resp_i;
    logic resp_d;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            starve_cnt_q  <= '0;
            ifetch_hold_q <= '0;
            dmem_hold_q   <= '0;
            flush_seen_q  <= 1'b0;
            store_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            starve_cnt_q  <= starve_cnt_d;
            ifetch_hold_q <= ifetch_hold_d;
            dmem_hold_q   <= dmem_hold_d;
            flush_seen_q  <= flush_seen_d;
            store_q       <= store_d;
        end
    end

    // A fetch that has been passed over STARVE_MAX times takes the next slot.
    always_comb begin
        dreq       = dmem_re_i | dmem_we_i;
        starve_hit = ifetch_req_i && (starve_cnt_q == 4'(STARVE_MAX));
        grant_d    = (state_q == IDLE) && dreq && !starve_hit;
        grant_i    = (state_q == IDLE) && !grant_d && ifetch_req_i;
        resp_i     = (state_q == WAIT_I) && (lat_cnt_q == 3'd0) && !flush_seen_q && !ifetch_flush_i;
        resp_d     = (state_q == WAIT_D) && (lat_cnt_q == 3'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = WAIT_D;
                end else if (grant_i) begin
                    state_d = WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lat_cnt_d     = lat_cnt_q;
        starve_cnt_d  = starve_cnt_q;
        ifetch_hold_d = ifetch_hold_q;
        dmem_hold_d   = dmem_hold_q;
        flush_seen_d  = flush_seen_q;
        store_d       = store_q;
        if (grant_d || grant_i) begin
            lat_cnt_d = 3'(MEM_LAT - 1);
        end else if ((state_q != IDLE) && (lat_cnt_q != 3'd0)) begin
            lat_cnt_d = lat_cnt_q - 3'd1;
        end
        if (grant_d) begin
            store_d = dmem_we_i;
            if (ifetch_req_i) begin
                if (starve_cnt_q < 4'(STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
        if (grant_i) begin
            starve_cnt_d = '0;
            flush_seen_d = 1'b0;
        end
        // A redirect anywhere in the fetch wait kills that response for good.
        if ((state_q == WAIT_I) && ifetch_flush_i) begin
            flush_seen_d = 1'b1;
        end
        if (resp_i) begin
            ifetch_hold_d = mem_rdata_i;
        end
        if (resp_d && !store_q) begin
            dmem_hold_d = mem_rdata_i;
        end
    end

    // Every output is forced quiet while reset is held, even comb paths from inputs.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        ifetch_valid_o = 1'b0;
        dmem_valid_o   = 1'b0;
        stall_fetch_o  = 1'b0;
        stall_exec_o   = 1'b0;
        if (resetn_i) begin
            if (grant_d) begin
                mem_req_o   = 1'b1;
                mem_we_o    = dmem_we_i;
                mem_addr_o  = dmem_addr_i;
                mem_wdata_o = dmem_wdata_i;
            end else if (grant_i) begin
                mem_req_o  = 1'b1;
                mem_addr_o = ifetch_addr_i;
            end
            ifetch_valid_o = resp_i;
            dmem_valid_o   = resp_d;
            stall_fetch_o  = ifetch_req_i & ~resp_i;
            stall_exec_o   = dreq & ~resp_d;
        end
        ifetch_rdata_o = ifetch_valid_o ? mem_rdata_i : ifetch_hold_q;
        dmem_rdata_o   = (dmem_valid_o && !store_q) ? mem_rdata_i : dmem_hold_q;
    end

endmodule
